bitorder_conv: RTL and testbench

BITORDER_CONV -- requirements
Module: bitorder_conv

---
 rtl/bitorder_pkg.sv | 14 +
 rtl/bitorder_lane_buf.sv | 30 +++
 rtl/bitorder_conv.sv | 121 ++++++++++++
 tb/tb_bitorder_conv.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitorder_pkg.sv
// Shared types and helpers for the lane bit-order converter.
package bitorder_pkg;

    typedef enum logic {
        ORDER_LSB_FIRST = 1'b0,
        ORDER_MSB_FIRST = 1'b1
    } order_e;

    function automatic int unsigned lanes_per_word(input int unsigned word_w,
                                                   input int unsigned lane_w);
        return word_w / lane_w;
    endfunction

endpackage

// File: rtl/bitorder_lane_buf.sv
// One word buffer: slot-indexed lane write, synchronous clear, lane-indexed read.
module bitorder_lane_buf #(
    parameter int unsigned LANE_W = 2,
    parameter int unsigned N      = 4,
    parameter int unsigned SW     = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              we,
    input  logic [SW-1:0]     wr_slot,
    input  logic [LANE_W-1:0] wr_data,
    input  logic [SW-1:0]     rd_slot,
    output logic [LANE_W-1:0] rd_data_c
);

    logic [LANE_W-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (clr) begin
            for (int unsigned i = 0; i < N; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wr_slot] <= wr_data;
        end
    end

    assign rd_data_c = mem[rd_slot];

endmodule

// File: rtl/bitorder_conv.sv
// Lane-serial word bit-order converter with ping-pong word buffers.
// Optional BITORDER_CONV_ERR_EN adds the err_trunc partial-word pulse output.
module bitorder_conv
    import bitorder_pkg::*;
#(
    parameter int unsigned LANE_W = 2,
    parameter int unsigned WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              axiiv,
    input  logic [LANE_W-1:0] axiid,
    input  logic              order_sel,
    output logic              axiov,
    output logic [LANE_W-1:0] axiod
`ifdef BITORDER_CONV_ERR_EN
    ,
    output logic              err_trunc
`endif
);

    localparam int unsigned N  = lanes_per_word(WORD_W, LANE_W);
    localparam int unsigned SW = (N > 1) ? $clog2(N) : 1;

    logic [SW-1:0]     slot;
    logic [SW-1:0]     didx;
    logic              draining;
    logic              wr_sel;
    logic              rd_sel;
    order_e            ord;

    logic              start_c;
    logic              rd_buf_c;
    logic [SW-1:0]     rd_slot_c;
    logic [LANE_W-1:0] rd0_c;
    logic [LANE_W-1:0] rd1_c;
    logic [LANE_W-1:0] lane_c;

    // Last lane of a word arriving: swap buffers and begin draining this cycle.
    assign start_c = axiiv && (slot == SW'(N - 1));

    // On start the only lane needed from memory is slot 0 of the filling buffer.
    always_comb begin
        rd_buf_c  = rd_sel;
        rd_slot_c = (ord == ORDER_MSB_FIRST) ? didx : (SW'(N - 1) - didx);
        if (start_c) begin
            rd_buf_c  = wr_sel;
            rd_slot_c = '0;
        end
        lane_c = rd_buf_c ? rd1_c : rd0_c;
    end

    bitorder_lane_buf #(.LANE_W(LANE_W), .N(N), .SW(SW)) u_buf0 (
        .clk       (clk),
        .clr       (!rst),
        .we        (axiiv && !wr_sel),
        .wr_slot   (slot),
        .wr_data   (axiid),
        .rd_slot   (rd_slot_c),
        .rd_data_c (rd0_c)
    );

    bitorder_lane_buf #(.LANE_W(LANE_W), .N(N), .SW(SW)) u_buf1 (
        .clk       (clk),
        .clr       (!rst),
        .we        (axiiv && wr_sel),
        .wr_slot   (slot),
        .wr_data   (axiid),
        .rd_slot   (rd_slot_c),
        .rd_data_c (rd1_c)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            slot     <= '0;
            didx     <= '0;
            draining <= 1'b0;
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            ord      <= ORDER_LSB_FIRST;
            axiov    <= 1'b0;
            axiod    <= '0;
        end else begin
            if (!axiiv || start_c) begin
                slot <= '0;
            end else begin
                slot <= slot + SW'(1);
            end

            // With LSB-first order the first emitted lane is the one arriving now.
            if (start_c) begin
                ord      <= order_e'(order_sel);
                wr_sel   <= !wr_sel;
                rd_sel   <= wr_sel;
                didx     <= SW'(1);
                draining <= 1'b1;
                axiov    <= 1'b1;
                axiod    <= (order_e'(order_sel) == ORDER_MSB_FIRST) ? lane_c : axiid;
            end else if (draining) begin
                didx     <= didx + SW'(1);
                draining <= (didx != SW'(N - 1));
                axiov    <= 1'b1;
                axiod    <= lane_c;
            end else begin
                axiov    <= 1'b0;
                axiod    <= '0;
            end
        end
    end

`ifdef BITORDER_CONV_ERR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_trunc <= 1'b0;
        end else begin
            err_trunc <= !axiiv && (slot != '0);
        end
    end
`endif

endmodule

// File: tb/tb_bitorder_conv.sv
// Scoreboard bench for bitorder_conv: default 2/8 instance plus a 4/16 instance.
module tb_bitorder_conv;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    logic       clk = 1'b0;
    int         cyc = 0;

    logic       rst_a = 1'b0;
    logic       axiiv_a = 1'b0;
    logic [1:0] axiid_a = '0;
    logic       order_sel_a = 1'b0;
    logic       axiov_a;
    logic [1:0] axiod_a;

    logic       rst_b = 1'b0;
    logic       axiiv_b = 1'b0;
    logic [3:0] axiid_b = '0;
    logic       order_sel_b = 1'b0;
    logic       axiov_b;
    logic [3:0] axiod_b;

`ifdef BITORDER_CONV_ERR_EN
    logic       err_a;
    logic       err_b;
`endif

    exp_t q_a[$];
    exp_t q_b[$];
    int   eq_err[$];

    int          part_n_a = 0;
    logic [15:0] part_w_a = '0;
    int          part_n_b = 0;
    logic [15:0] part_w_b = '0;

    int   vectors = 0;
    int   miscompares = 0;
    logic done = 1'b0;

    bitorder_conv u_dut_a (
        .clk       (clk),
        .rst       (rst_a),
        .axiiv     (axiiv_a),
        .axiid     (axiid_a),
        .order_sel (order_sel_a),
        .axiov     (axiov_a),
        .axiod     (axiod_a)
`ifdef BITORDER_CONV_ERR_EN
        ,
        .err_trunc (err_a)
`endif
    );

    bitorder_conv #(.LANE_W(4), .WORD_W(16)) u_dut_b (
        .clk       (clk),
        .rst       (rst_b),
        .axiiv     (axiiv_b),
        .axiid     (axiid_b),
        .order_sel (order_sel_b),
        .axiov     (axiov_b),
        .axiod     (axiod_b)
`ifdef BITORDER_CONV_ERR_EN
        ,
        .err_trunc (err_b)
`endif
    );

    always #5 clk = !clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: accumulate lanes MS-first into a word, then split by arithmetic.
    task automatic model_a(input logic v, input logic [1:0] d, input logic osel);
        exp_t e;
        if (v) begin
            part_w_a = (part_w_a << 2) | 16'(d);
            part_n_a++;
            if (part_n_a == 4) begin
                for (int i = 0; i < 4; i++) begin
                    e.data = osel ? ((part_w_a >> ((3 - i) * 2)) & 16'h3)
                                  : ((part_w_a >> (i * 2)) & 16'h3);
                    e.cyc  = cyc + 1 + i;
                    q_a.push_back(e);
                end
                part_n_a = 0;
                part_w_a = '0;
            end
        end else begin
            if (part_n_a != 0) eq_err.push_back(cyc + 1);
            part_n_a = 0;
            part_w_a = '0;
        end
    endtask

    task automatic model_b(input logic v, input logic [3:0] d, input logic osel);
        exp_t e;
        if (v) begin
            part_w_b = (part_w_b << 4) | 16'(d);
            part_n_b++;
            if (part_n_b == 4) begin
                for (int i = 0; i < 4; i++) begin
                    e.data = osel ? ((part_w_b >> ((3 - i) * 4)) & 16'hF)
                                  : ((part_w_b >> (i * 4)) & 16'hF);
                    e.cyc  = cyc + 1 + i;
                    q_b.push_back(e);
                end
                part_n_b = 0;
                part_w_b = '0;
            end
        end else begin
            part_n_b = 0;
            part_w_b = '0;
        end
    endtask

    task automatic cycle_a(input logic v, input logic [1:0] d, input logic osel, input logic r);
        axiiv_a = v;
        axiid_a = d;
        order_sel_a = osel;
        rst_a = r;
        if (!r) begin
            while (q_a.size() > 0 && q_a[$].cyc > cyc) void'(q_a.pop_back());
            while (eq_err.size() > 0 && eq_err[$] > cyc) void'(eq_err.pop_back());
            part_n_a = 0;
            part_w_a = '0;
        end else begin
            model_a(v, d, osel);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_b(input logic v, input logic [3:0] d, input logic osel, input logic r);
        axiiv_b = v;
        axiid_b = d;
        order_sel_b = osel;
        rst_b = r;
        if (!r) begin
            while (q_b.size() > 0 && q_b[$].cyc > cyc) void'(q_b.pop_back());
            part_n_b = 0;
            part_w_b = '0;
        end else begin
            model_b(v, d, osel);
        end
        @(posedge clk);
        #1;
    endtask

    // Slots 0-1 use osel_lo, slots 2-3 use osel_hi.
    task automatic word_a(input logic [7:0] w, input logic osel_lo, input logic osel_hi);
        for (int k = 0; k < 4; k++) begin
            cycle_a(1'b1, w[7 - 2 * k -: 2], (k < 2) ? osel_lo : osel_hi, 1'b1);
        end
    endtask

    task automatic word_b(input logic [15:0] w, input logic osel);
        for (int k = 0; k < 4; k++) begin
            cycle_b(1'b1, w[15 - 4 * k -: 4], osel, 1'b1);
        end
    endtask

    // Monitor: every cycle each output must match exactly what is due this cycle.
    always @(negedge clk) begin
        exp_t e;
        logic ev;
        logic [15:0] ed;
        logic ee;

        ev = 1'b0;
        ed = '0;
        while (q_a.size() > 0 && q_a[0].cyc < cyc) begin
            e = q_a.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL a_stale cyc=%0d expected lane %0h at cyc %0d never seen", cyc, e.data, e.cyc);
        end
        if (q_a.size() > 0 && q_a[0].cyc == cyc) begin
            e  = q_a.pop_front();
            ev = 1'b1;
            ed = e.data;
        end
        vectors++;
        if (axiov_a !== ev || axiod_a !== ed[1:0]) begin
            miscompares++;
            $display("FAIL a_out cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, axiov_a, axiod_a, ev, ed[1:0]);
        end

        ev = 1'b0;
        ed = '0;
        while (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            e = q_b.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL b_stale cyc=%0d expected lane %0h at cyc %0d never seen", cyc, e.data, e.cyc);
        end
        if (q_b.size() > 0 && q_b[0].cyc == cyc) begin
            e  = q_b.pop_front();
            ev = 1'b1;
            ed = e.data;
        end
        vectors++;
        if (axiov_b !== ev || axiod_b !== ed[3:0]) begin
            miscompares++;
            $display("FAIL b_out cyc=%0d got v=%b d=%h want v=%b d=%h", cyc, axiov_b, axiod_b, ev, ed[3:0]);
        end

        ee = 1'b0;
        while (eq_err.size() > 0 && eq_err[0] < cyc) void'(eq_err.pop_front());
        if (eq_err.size() > 0 && eq_err[0] == cyc) begin
            void'(eq_err.pop_front());
            ee = 1'b1;
        end
`ifdef BITORDER_CONV_ERR_EN
        vectors++;
        if (err_a !== ee) begin
            miscompares++;
            $display("FAIL a_err cyc=%0d got err_trunc=%b want %b", cyc, err_a, ee);
        end
`endif

        if (done) begin
            vectors++;
            if (q_a.size() != 0 || q_b.size() != 0) begin
                miscompares++;
                $display("FAIL drain_left got %0d/%0d pending lanes want 0/0", q_a.size(), q_b.size());
            end
        end
    end

    initial begin
        logic [1:0] d2;
        logic [3:0] d4;

        @(posedge clk);
        #1;
        // Reset state on both instances.
        repeat (3) cycle_a(1'b0, 2'b00, 1'b0, 1'b0);
        rst_b = 1'b1;
        repeat (2) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // 0xB4 LSB-first, then MSB-first.
        word_a(8'hB4, 1'b0, 1'b0);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);
        word_a(8'hB4, 1'b1, 1'b1);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Order changes mid-word: only the value at the last slot counts.
        word_a(8'hB4, 1'b1, 1'b1);
        word_a(8'hB4, 1'b1, 1'b0);
        word_a(8'h1E, 1'b0, 1'b1);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Back-to-back words with no output gap.
        word_a(8'hB4, 1'b0, 1'b0);
        word_a(8'h1E, 1'b0, 1'b0);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Truncated fragment followed by a full word.
        cycle_a(1'b1, 2'b11, 1'b0, 1'b1);
        cycle_a(1'b1, 2'b10, 1'b0, 1'b1);
        cycle_a(1'b1, 2'b01, 1'b0, 1'b1);
        cycle_a(1'b0, 2'b00, 1'b0, 1'b1);
        word_a(8'h55, 1'b0, 1'b0);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Drop while a previous word drains.
        word_a(8'hB4, 1'b1, 1'b1);
        cycle_a(1'b1, 2'b10, 1'b0, 1'b1);
        cycle_a(1'b0, 2'b00, 1'b0, 1'b1);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Reset during the second output lane, then a clean word.
        word_a(8'hB4, 1'b0, 1'b0);
        cycle_a(1'b0, 2'b00, 1'b0, 1'b1);
        cycle_a(1'b0, 2'b00, 1'b0, 1'b0);
        word_a(8'hB4, 1'b0, 1'b0);
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Randomized traffic with occasional drops, order flips and resets.
        repeat (500) begin
            d2 = 2'($urandom_range(0, 3));
            cycle_a($urandom_range(0, 9) != 0, d2, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 99) != 0);
        end
        repeat (6) cycle_a(1'b0, 2'b00, 1'b0, 1'b1);

        // Wide-lane instance: 0xABCD LSB-first and MSB-first, then random.
        word_b(16'hABCD, 1'b0);
        repeat (6) cycle_b(1'b0, 4'h0, 1'b0, 1'b1);
        word_b(16'hABCD, 1'b1);
        word_b(16'h1234, 1'b0);
        repeat (6) cycle_b(1'b0, 4'h0, 1'b0, 1'b1);
        repeat (300) begin
            d4 = 4'($urandom_range(0, 15));
            cycle_b($urandom_range(0, 9) != 0, d4, 1'($urandom_range(0, 1)),
                    $urandom_range(0, 99) != 0);
        end
        repeat (8) cycle_b(1'b0, 4'h0, 1'b0, 1'b1);

        done = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
